aes192_inv_key_sched: RTL
=========================

# aes192_inv_key_sched

Sequential AES-192 decryption key schedule. It accepts a 192-bit cipher key and expands forward one word per cycle to the end of the schedule. It then walks the expansion backwards one word per cycle, emitting the 13 round keys in decryption order (round 12 down to round 0) over a valid/ready stream. It sits on the decrypt side of the AES-192 datapath and feeds the inverse-cipher round logic, mirroring the encrypt-side key expansion.

## Interface
- No parameters (fixed AES-192: Nk=6, Nr=12, 52 words).
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- key_in  input  192  cipher key; [191:160] = w[0] … [31:0] = w[5].
- busy  output  1  high in every state except IDLE.
- rk_valid  output  1  rk_data/rk_idx hold a round key.
- rk_ready  input  1  consumer accepts when rk_valid & rk_ready.
- rk_data  output  128  round key; [127:96] = w[4k] … [31:0] = w[4k+3].
- rk_idx  output  4  round number k (12 → 0).
- rk_last  output  1  high with rk_valid when rk_idx = 0.

## Operation
- State: six 32-bit window registers win[0..5] holding w[t-5..t], a 6-bit top index t, and t mod 6 tracked by a separate counter (no divider).
- temp(x, i) = SubWord(RotWord(x)) ^ Rcon[i/6] when i mod 6 = 0, else x. Rcon[1..8] = 01,02,04,08,10,20,40,80 (as byte 3).
- FSM IDLE → FWD → EMIT ⇄ BWD → IDLE.
- IDLE: on start, load win ← key_in, t ← 5, go to FWD. The key is not latched elsewhere.
- FWD: shift the window up; the new top is w[t+1] = w[t-5] ^ temp(w[t], t+1); t ← t+1. When t becomes 51, go to EMIT.
- EMIT: rk_valid = 1. Key k is the four consecutive window words starting at slot 4k-(t-5); this is slots 2..5 for k ≥ 1 and slots 0..3 for k = 0.
  - On handshake with k > 0: go to BWD.
  - On handshake with k = 0: go to IDLE.
- BWD: shift the window down; the new bottom is w[t-6] = w[t] ^ temp(w[t-1], t); t ← t-1.
  - Return to EMIT when t = 4(k-1)+3, i.e. 4 steps, or when t = 5 for k-1 = 0, i.e. 2 steps.
  - k is decremented on the EMIT handshake.
- A single SubWord instance is shared by FWD and BWD via an input mux.
- start is ignored while busy.
- rk_ready is ignored while rk_valid = 0.
- While rk_valid = 1, rk_data and rk_idx are stable until the handshake.

## Timing
- Reset values:
  - State IDLE.
  - busy = 0, rk_valid = 0, rk_last = 0.
  - rk_data = 0, rk_idx = 0.
  - Window and t cleared.
- Start accepted at edge E0 → FWD during E1..E46 → rk_valid = 1 (k = 12) in the cycle after E46. First-key latency is 46 cycles.
- With rk_ready held high:
  - keys 12..2 arrive every 5 cycles (1 EMIT + 4 BWD);
  - key 1 → key 0 takes 3 cycles;
  - busy drops the cycle after the key-0 handshake. A new start is accepted in that cycle.
- rst asserted mid-FWD, mid-BWD or mid-EMIT: immediate return to IDLE with rk_valid = 0. No partial key is emitted afterwards.
- rk_ready low stalls indefinitely in EMIT with no state change.

## Structure
- Shared package aes_pkg:
  - S-box table or function;
  - RCON constant array, indices 1..10;
  - state enum for this FSM;
  - word typedef (logic [31:0]).
- One sub-module: sub_word (4 parallel S-box lookups, combinational), reused by the encrypt-side key expansion.
- Everything else stays in aes192_inv_key_sched: window registers, counters and FSM.

## Test plan
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, start pulse, rk_ready = 1:
  - first key, 46 cycles after start: rk_idx = 12, rk_data = e98ba06f448c773c8ecc720401002202;
  - rk_idx = 1: 62f8ead2522c6b7bfe0c91f72402f5a5;
  - rk_idx = 0: 8e73b0f7da0e6452c810f32b809079e5, with rk_last = 1.
- Same key, random rk_ready backpressure: the identical 13-key sequence arrives, and rk_data is stable across every stalled cycle.
- start held high continuously: exactly one schedule per IDLE visit. The second run begins the cycle after the key-0 handshake, and no start is accepted while busy.
- rst asserted at cycle 20 of FWD and at rk_idx = 7: all outputs return to reset values at once; restarting with the A.2 key reproduces the correct sequence.
- Cross-check against a reference model for 200 random keys: all 13 keys match the forward expansion in reverse order, and the count is always 13 with rk_last only on the last one.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, S-box, round constants and key-schedule states
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_EMIT,
        ST_BWD
    } ks_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is unused; round constants live at indices 1..10.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        return (idx <= 4'd10) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/sub_word.sv
// rtl/sub_word.sv - AES SubWord: four parallel S-box lookups, purely combinational
//   word_i : input word
//   word_o : byte-wise S-box substitution of word_i
module sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes192_inv_key_sched.sv
// rtl/aes192_inv_key_sched.sv - AES-192 decryption key schedule, round keys 12 down to 0
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a schedule from key_in (only looked at while idle)
//   key_in    : 192-bit cipher key, w[0] in the top word
//   busy      : schedule in progress
//   rk_valid / rk_ready / rk_data / rk_idx / rk_last : round-key stream, round 12 first
module aes192_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);

    ks_state_e state_q, state_d;
    word_t     win_q [6];
    word_t     win_d [6];
    logic [5:0] t_q, t_d;         // index of the word held in win[5]
    logic [2:0] tmod_q, tmod_d;   // t mod 6
    logic [3:0] rnd_q, rnd_d;     // t div 6, selects the round constant
    logic [3:0] k_q, k_d;         // round key currently on offer

    word_t sub_in, sub_out;
    word_t fwd_word, bwd_word;
    logic [5:0] t_dec, bwd_stop_t;
    logic hs;

    // One S-box bank: forward step substitutes w[t], backward step w[t-1].
    always_comb begin
        sub_in = (state_q == ST_BWD) ? win_q[4] : win_q[5];
    end

    sub_word u_sub_word (
        .word_i ({sub_in[23:0], sub_in[31:24]}),
        .word_o (sub_out)
    );

    // w[t+1] = w[t-5] ^ temp(w[t], t+1); round boundary when (t+1) mod 6 == 0.
    assign fwd_word = win_q[0] ^ ((tmod_q == 3'd5)
                      ? (sub_out ^ {rcon(rnd_q + 4'd1), 24'h0}) : win_q[5]);
    // w[t-6] = w[t] ^ temp(w[t-1], t); round boundary when t mod 6 == 0.
    assign bwd_word = win_q[5] ^ ((tmod_q == 3'd0)
                      ? (sub_out ^ {rcon(rnd_q), 24'h0}) : win_q[4]);

    assign t_dec = t_q - 6'd1;
    // Key k (k>0) sits in slots 2..5 when t = 4k+3; key 0 sits in slots 0..3 at t = 5.
    assign bwd_stop_t = (k_q == 4'd0) ? 6'd5 : {k_q, 2'b11};

    assign hs = rk_valid & rk_ready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        tmod_d  = tmod_q;
        rnd_d   = rnd_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 6; i++) begin
                        win_d[i] = key_in[191 - 32*i -: 32];
                    end
                    t_d     = 6'd5;
                    tmod_d  = 3'd5;
                    rnd_d   = 4'd0;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                for (int i = 0; i < 5; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[5] = fwd_word;
                t_d      = t_q + 6'd1;
                if (tmod_q == 3'd5) begin
                    tmod_d = 3'd0;
                    rnd_d  = rnd_q + 4'd1;
                end else begin
                    tmod_d = tmod_q + 3'd1;
                end
                if (t_q == 6'd50) begin
                    k_d     = 4'd12;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    if (k_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q - 4'd1;
                        state_d = ST_BWD;
                    end
                end
            end
            ST_BWD: begin
                for (int i = 1; i < 6; i++) begin
                    win_d[i] = win_q[i-1];
                end
                win_d[0] = bwd_word;
                t_d      = t_dec;
                if (tmod_q == 3'd0) begin
                    tmod_d = 3'd5;
                    rnd_d  = rnd_q - 4'd1;
                end else begin
                    tmod_d = tmod_q - 3'd1;
                end
                if (t_dec == bwd_stop_t) begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 6; i++) begin
                win_q[i] <= '0;
            end
            t_q    <= '0;
            tmod_q <= '0;
            rnd_q  <= '0;
            k_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
            tmod_q  <= tmod_d;
            rnd_q   <= rnd_d;
            k_q     <= k_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rk_valid = (state_q == ST_EMIT);
    assign rk_last  = rk_valid && (k_q == 4'd0);
    assign rk_idx   = rk_valid ? k_q : 4'd0;

    always_comb begin
        rk_data = '0;
        if (rk_valid) begin
            if (k_q == 4'd0) begin
                rk_data = {win_q[0], win_q[1], win_q[2], win_q[3]};
            end else begin
                rk_data = {win_q[2], win_q[3], win_q[4], win_q[5]};
            end
        end
    end

endmodule
